cdr_ctrl: RTL and testbench
===========================

# cdr_ctrl

Sequencer for the CDR bit-recovery stage. Takes the raw oversampled phase stream from the demodulator, qualifies it with carrier detect, decimates to one phase per chip, and emits the single-cycle `ph_valid` pulses and held `phase_out` word that the bit-recovery datapath needs to capture a new phase per chip. It samples the returned `data_bits` at the correct cycle, drops the stale first bit of each burst, and frames the burst with start, end and timeout flags.

## Interface
- `OSR`, 4: phase samples per chip. Legal range is 2..16.
- `SAMPLE_IDX`, 1: sample index within the chip that is forwarded. Legal range is 0..OSR-1.
- `PH_W`, 6: phase width, signed two's complement.
- `SETTLE_CHIPS`, 8: chips `carrier_detect` must stay high before tracking starts.
- `MAX_CHIPS`, 1024: chip limit per burst before a forced timeout.
- `clk` input 1: single clock.
- `reset` input 1: reset, asynchronous, active-high.
- `cfg_enable` input 1: block enable. Low aborts any burst.
- `carrier_detect` input 1: front-end energy flag, level.
- `sample_in` input PH_W: raw phase, signed.
- `sample_valid` input 1: `sample_in` qualifier. At most one per cycle.
- `data_bits` input 1: bit from bit recovery, combinational on its side.
- `phase_out` output PH_W: decimated phase. Held between strobes.
- `ph_valid` output 1: one-cycle capture pulse to bit recovery.
- `bit_out` output 1: recovered bit.
- `bit_valid` output 1: one-cycle qualifier for `bit_out`.
- `frame_start` output 1: pulse on entry to TRACK.
- `frame_end` output 1: pulse on TRACK exit, for any cause except abort.
- `timeout` output 1: pulse when `MAX_CHIPS` is reached.
- `busy` output 1: high in any state other than IDLE.

## Operation
States are IDLE, SETTLE, TRACK and FLUSH. The state register is encoded in 2 bits.

- **IDLE**: counters are cleared. If `cfg_enable` and `carrier_detect` are both high, go to SETTLE.
- **SETTLE**:
  - The sample counter runs. The chip counter increments on each chip boundary, i.e. each valid sample with sample count == OSR-1.
  - If `carrier_detect` goes low, return to IDLE.
  - When the chip count reaches SETTLE_CHIPS, go to TRACK, clear the chip counter, and pulse `frame_start`.
- **TRACK**:
  - On each valid sample with sample count == SAMPLE_IDX: register `sample_in` into `phase_out` and assert `ph_valid` for exactly one cycle.
  - Two cycles after each `ph_valid` pulse, register `data_bits` into `bit_out` and pulse `bit_valid` the next cycle.
  - The bit from the first `ph_valid` pulse of a burst is suppressed, because the downstream previous phase is stale. The burst therefore yields N-1 bits for N chips.
  - The chip counter increments per `ph_valid` pulse.
  - If `carrier_detect` goes low, go to FLUSH.
  - If the chip count reaches MAX_CHIPS, pulse `timeout` and go to FLUSH.
- **FLUSH**: wait 3 cycles so the in-flight bit completes. No new `ph_valid` pulses are issued. Then pulse `frame_end` and go to IDLE.
- **Abort**: `cfg_enable` low in any state forces IDLE on the next edge. Pending `bit_valid` pulses are cancelled, and `frame_end` is not pulsed.
- Sample counter arithmetic: modulo OSR, advancing only on `sample_valid`. It is cleared on IDLE entry. It is not cleared on the SETTLE to TRACK transition, so chip alignment is preserved.
- Chip counter: 11 bits (clog2(MAX_CHIPS)+1) and saturating.
- Phase is passed through untouched. No arithmetic is performed on it.

## Timing
- **Reset values**:
  - State is IDLE.
  - `phase_out` = 0.
  - `ph_valid`, `bit_out`, `bit_valid`, `frame_start`, `frame_end`, `timeout` and `busy` are all 0.
- **Capture latency**: `sample_valid` at edge t gives `phase_out` and `ph_valid` at t+1.
  - `data_bits` is sampled at t+3.
  - `bit_valid` is high during t+4.
- `phase_out` is stable for at least OSR-1 cycles after each pulse. The downstream block captures it in the cycle after `ph_valid`.
- `ph_valid` pulses are at least 2 cycles apart. This is guaranteed by OSR≥2 and one sample per cycle.
- **Simultaneous events**, priority from highest: abort, then timeout, then carrier loss, then strobe.
  - A strobe sample arriving in the same cycle as the TRACK exit is dropped.
- Reset asserted mid-burst clears everything immediately. No pulses are emitted.

## Structure
- Package `cdr_pkg` holds:
  - the `cdr_ctrl_state_t` enum (IDLE, SETTLE, TRACK, FLUSH);
  - the `PH_W` default;
  - a `FLUSH_CYCLES=3` constant. This constant is shared with the bit recovery latency.
- One natural sub-module, `cdr_chip_counter`: the modulo-OSR sample counter plus the saturating chip counter. It provides chip-boundary and strobe-index outputs.
- The FSM, the bit-sampling delay line (2-stage valid shift) and the first-bit suppression flag stay in `cdr_ctrl`.

## Test plan
- **Reset and idle**: `reset` pulse, then `cfg_enable`=1 and `carrier_detect`=0 for 100 cycles. Required: all outputs stay 0 and `busy`=0.
- **Nominal burst**: OSR=4, continuous `sample_valid`, `carrier_detect` high for 8+20 chips. Required:
  - `frame_start` after 32 valid samples;
  - 20 `ph_valid` pulses spaced 4 cycles, each carrying the sample at index 1;
  - 19 `bit_valid` pulses;
  - `frame_end` 3 cycles after `carrier_detect` falls.
- **Gapped input**: `sample_valid` at 50% duty. Required: strobe spacing is 8 cycles, and the bit count matches the chip count minus 1.
- **Settle failure**: `carrier_detect` drops at chip 5 of SETTLE. Required: return to IDLE, with no `frame_start` and no `ph_valid`.
- **Timeout**: MAX_CHIPS=16 with carrier held high. Required:
  - `timeout` pulse on the 16th `ph_valid`;
  - FLUSH, then `frame_end`;
  - a re-SETTLE, since carrier is still high.
- **Abort**: `cfg_enable` dropped in the cycle after a `ph_valid`. Required: no `bit_valid` for that chip, no `frame_end`, and state is IDLE the next cycle.

Source files
------------

// File: rtl/cdr_pkg.sv
// cdr_pkg: shared types and constants for the CDR sequencer.
// State encoding, default phase width, flush depth.
package cdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    TRACK,
    FLUSH
  } cdr_ctrl_state_t;

  localparam int CDR_PH_W = 6;

  // Matches the bit-recovery capture latency.
  localparam int FLUSH_CYCLES = 3;

endpackage

// File: rtl/cdr_chip_counter.sv
// cdr_chip_counter: modulo-OSR sample counter and saturating chip counter.
// Ports: clr/chip_clr/chip_inc control; chip_bound, strobe, chip_cnt out.
module cdr_chip_counter #(
  parameter int OSR        = 4,
  parameter int SAMPLE_IDX = 1,
  parameter int MAX_CHIPS  = 1024,
  parameter int CW         = $clog2(MAX_CHIPS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          chip_clr,
  input  logic          chip_inc,
  input  logic          sample_valid,
  output logic          chip_bound,
  output logic          strobe,
  output logic [CW-1:0] chip_cnt
);

  localparam int SW = $clog2(OSR);
  localparam logic [SW-1:0] S_LAST = SW'(OSR - 1);
  localparam logic [SW-1:0] S_IDX  = SW'(SAMPLE_IDX);
  localparam logic [CW-1:0] C_SAT  = '1;

  logic [SW-1:0] scnt;

  assign chip_bound = sample_valid && (scnt == S_LAST);
  assign strobe     = sample_valid && (scnt == S_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt     <= '0;
      chip_cnt <= '0;
    end else if (clr) begin
      scnt     <= '0;
      chip_cnt <= '0;
    end else begin
      if (sample_valid)
        scnt <= chip_bound ? '0 : scnt + 1'b1;
      if (chip_clr)
        chip_cnt <= '0;
      else if (chip_inc && chip_cnt != C_SAT)
        chip_cnt <= chip_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cdr_ctrl.sv
// cdr_ctrl: CDR sequencer - qualifies, decimates and frames phase bursts.
// Ports: sample stream in, phase_out/ph_valid, bit_out/bit_valid, frame flags.
module cdr_ctrl
  import cdr_pkg::*;
#(
  parameter int OSR          = 4,
  parameter int SAMPLE_IDX   = 1,
  parameter int PH_W         = CDR_PH_W,
  parameter int SETTLE_CHIPS = 8,
  parameter int MAX_CHIPS    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_enable,
  input  logic                   carrier_detect,
  input  logic signed [PH_W-1:0] sample_in,
  input  logic                   sample_valid,
  input  logic                   data_bits,
  output logic signed [PH_W-1:0] phase_out,
  output logic                   ph_valid,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   timeout,
  output logic                   busy
);

  localparam int CW = $clog2(MAX_CHIPS) + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CHIPS - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MAX_CHIPS - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(FLUSH_CYCLES - 1);

  cdr_ctrl_state_t state;

  logic [FW-1:0] fcnt;
  logic [CW-1:0] chip_cnt;
  logic          chip_bound;
  logic          strobe;
  logic          settle_done;
  logic          tmo;
  logic          issue;
  logic          first;
  logic          ph_keep;
  logic          d1;
  logic          d2;

  assign settle_done = (state == SETTLE) && carrier_detect &&
                       chip_bound && (chip_cnt == SET_LAST);
  assign tmo   = (state == TRACK) && strobe && (chip_cnt >= TMO_LAST);
  // Carrier loss drops a coincident strobe; the timeout strobe wins.
  assign issue = cfg_enable && (state == TRACK) && strobe &&
                 (carrier_detect || tmo);

  cdr_chip_counter #(
    .OSR        (OSR),
    .SAMPLE_IDX (SAMPLE_IDX),
    .MAX_CHIPS  (MAX_CHIPS),
    .CW         (CW)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .clr          (state == IDLE),
    .chip_clr     (settle_done),
    .chip_inc     (((state == SETTLE) && chip_bound) || issue),
    .sample_valid (sample_valid),
    .chip_bound   (chip_bound),
    .strobe       (strobe),
    .chip_cnt     (chip_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fcnt        <= '0;
      first       <= 1'b0;
      ph_keep     <= 1'b0;
      d1          <= 1'b0;
      d2          <= 1'b0;
      phase_out   <= '0;
      ph_valid    <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ph_valid    <= 1'b0;
      ph_keep     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      timeout     <= 1'b0;
      d1          <= ph_keep;
      d2          <= d1;
      bit_valid   <= d2;
      if (d2)
        bit_out <= data_bits;
      if (issue) begin
        phase_out <= sample_in;
        ph_valid  <= 1'b1;
        // First chip's bit pairs with a stale previous phase.
        ph_keep   <= !first;
        first     <= 1'b0;
      end
      if (!cfg_enable) begin
        state     <= IDLE;
        busy      <= 1'b0;
        d1        <= 1'b0;
        d2        <= 1'b0;
        bit_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (carrier_detect) begin
              state <= SETTLE;
              busy  <= 1'b1;
            end
          end
          SETTLE: begin
            if (!carrier_detect) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (settle_done) begin
              state       <= TRACK;
              frame_start <= 1'b1;
              first       <= 1'b1;
            end
          end
          TRACK: begin
            // frame_end lands with the last possible in-flight bit;
            // a timeout strobe is one cycle younger than any
            // strobe issued before a carrier loss.
            if (tmo) begin
              state   <= FLUSH;
              timeout <= 1'b1;
              fcnt    <= '0;
            end else if (!carrier_detect) begin
              state <= FLUSH;
              fcnt  <= FW'(1);
            end
          end
          FLUSH: begin
            if (fcnt == F_LAST) begin
              state     <= IDLE;
              busy      <= 1'b0;
              frame_end <= 1'b1;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdr_ctrl.sv
// tb_cdr_ctrl: scoreboard bench for cdr_ctrl.
// Two instances: default limits (a) and MAX_CHIPS=16 (b).
module tb_cdr_ctrl;

  localparam int OSR  = 4;
  localparam int SIDX = 1;
  localparam int PH_W = 6;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_enable = 1'b0;
  logic carrier_detect = 1'b0;
  logic [PH_W-1:0] sample_in = '0;
  logic sample_valid = 1'b0;
  logic data_bits = 1'b0;

  logic [PH_W-1:0] po_a, po_b;
  logic pv_a, pv_b, bo_a, bo_b, bv_a, bv_b;
  logic fs_a, fs_b, fe_a, fe_b, to_a, to_b, busy_a, busy_b;

  cdr_ctrl u_a (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
    .carrier_detect(carrier_detect), .sample_in(sample_in),
    .sample_valid(sample_valid), .data_bits(data_bits),
    .phase_out(po_a), .ph_valid(pv_a), .bit_out(bo_a),
    .bit_valid(bv_a), .frame_start(fs_a), .frame_end(fe_a),
    .timeout(to_a), .busy(busy_a)
  );

  cdr_ctrl #(.MAX_CHIPS(16)) u_b (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
    .carrier_detect(carrier_detect), .sample_in(sample_in),
    .sample_valid(sample_valid), .data_bits(data_bits),
    .phase_out(po_b), .ph_valid(pv_b), .bit_out(bo_b),
    .bit_valid(bv_b), .frame_start(fs_b), .frame_end(fe_b),
    .timeout(to_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t ph_q[$];
  exp_t bit_q[$];
  logic db [4096];
  bit sel_b = 1'b0;
  bit first_chip = 1'b1;
  int pv_n, bv_n, fs_n, fe_n, to_n;
  int fs_c, fe_c, to_c;
  int exp_fs, last_strobe;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic pv, bv, fs, fe, to, bo;
    logic [PH_W-1:0] po;
    pv = sel_b ? pv_b : pv_a;
    bv = sel_b ? bv_b : bv_a;
    fs = sel_b ? fs_b : fs_a;
    fe = sel_b ? fe_b : fe_a;
    to = sel_b ? to_b : to_a;
    bo = sel_b ? bo_b : bo_a;
    po = sel_b ? po_b : po_a;
    if (!reset) begin
      if (pv) begin
        pv_n++;
        if (ph_q.size() == 0) check("ph_extra", 1, 0);
        else begin
          e = ph_q.pop_front();
          check("ph_cyc", cyc, e.cyc);
          check("ph_val", int'(po), e.val);
        end
      end
      if (bv) begin
        bv_n++;
        if (bit_q.size() == 0) check("bit_extra", 1, 0);
        else begin
          e = bit_q.pop_front();
          check("bit_cyc", cyc, e.cyc);
          check("bit_val", int'(bo), int'(db[(e.cyc - 1) & 4095]));
        end
      end
      if (fs) begin fs_n++; fs_c = cyc; end
      if (fe) begin fe_n++; fe_c = cyc; end
      if (to) begin to_n++; to_c = cyc; end
    end
  end

  task automatic drive(input bit sv, input bit cd, input bit en,
                       input logic [PH_W-1:0] ph);
    sample_valid   = sv;
    carrier_detect = cd;
    cfg_enable     = en;
    sample_in      = ph;
    data_bits      = 1'($urandom_range(0, 1));
    db[cyc & 4095] = data_bits;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_enable = 1'b1;
    carrier_detect = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    @(posedge clk);
    #1;
    ph_q.delete();
    bit_q.delete();
    first_chip = 1'b1;
    pv_n = 0; bv_n = 0; fs_n = 0; fe_n = 0; to_n = 0;
    fs_c = -1; fe_c = -1; to_c = -1;
    reset = 1'b0;
  endtask

  task automatic settle(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      exp_fs = cyc + 1;
      drive(1'b1, 1'b1, 1'b1, PH_W'($urandom));
      repeat (gap) drive(1'b0, 1'b1, 1'b1, '0);
    end
  endtask

  task automatic track(input int n, input int gap);
    exp_t e;
    logic [PH_W-1:0] ph;
    for (int i = 0; i < n; i++) begin
      ph = PH_W'($urandom);
      if (i % OSR == SIDX) begin
        e.cyc = cyc + 1;
        e.val = int'(ph);
        ph_q.push_back(e);
        if (!first_chip) begin
          e.cyc = cyc + 4;
          e.val = 0;
          bit_q.push_back(e);
        end
        first_chip = 1'b0;
        last_strobe = cyc;
      end
      drive(1'b1, 1'b1, 1'b1, ph);
      repeat (gap) drive(1'b0, 1'b1, 1'b1, '0);
    end
  endtask

  task automatic burst_end(input int n_pv, input int gap);
    int fall;
    check("fs_n", fs_n, 1);
    check("fs_cyc", fs_c, exp_fs);
    fall = cyc;
    repeat (8) drive(1'b0, 1'b0, 1'b1, '0);
    check("fe_n", fe_n, 1);
    check("fe_cyc", fe_c, fall + 3);
    check("pv_n", pv_n, n_pv);
    check("bv_n", bv_n, n_pv - 1);
    check("ph_left", ph_q.size(), 0);
    check("bit_left", bit_q.size(), 0);
    check("busy_end", int'(busy_a), 0);
    check("gap_tag", gap, gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int bad;
    exp_t e;
    // reset values and idle with carrier absent
    do_reset();
    check("rst_po", int'(po_a), 0);
    check("rst_pv", int'(pv_a), 0);
    check("rst_bo", int'(bo_a), 0);
    check("rst_bv", int'(bv_a), 0);
    check("rst_fs", int'(fs_a), 0);
    check("rst_fe", int'(fe_a), 0);
    check("rst_to", int'(to_a), 0);
    check("rst_busy", int'(busy_a), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b1, PH_W'($urandom));
      bad += int'(pv_a | bv_a | fs_a | fe_a | to_a | busy_a | bo_a);
      bad += int'(pv_b | bv_b | fs_b | fe_b | to_b | busy_b | bo_b);
      bad += int'(po_a != '0);
    end
    check("idle_quiet", bad, 0);

    // nominal burst, continuous samples
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0);
    settle(32, 0);
    track(80, 0);
    burst_end(20, 0);

    // 50% duty samples
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0);
    settle(32, 1);
    track(80, 1);
    burst_end(20, 1);

    // reset mid-burst
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0);
    settle(32, 0);
    track(10, 0);
    check("mid_busy_pre", int'(busy_a), 1);
    do_reset();
    check("mid_po", int'(po_a), 0);
    check("mid_busy", int'(busy_a), 0);
    repeat (6) drive(1'b0, 1'b0, 1'b1, '0);
    check("mid_pulses", pv_n + bv_n + fe_n, 0);

    // carrier lost at chip 5 of settle
    do_reset();
    drive(1'b0, 1'b1, 1'b1, '0);
    settle(20, 0);
    repeat (40) drive(1'b1, 1'b0, 1'b1, PH_W'($urandom));
    check("sf_fs", fs_n, 0);
    check("sf_pv", pv_n, 0);
    check("sf_busy", int'(busy_a), 0);

    // timeout on the 16-chip instance
    do_reset();
    sel_b = 1'b1;
    drive(1'b0, 1'b1, 1'b1, '0);
    settle(32, 0);
    track(64, 0);
    repeat (10) drive(1'b1, 1'b1, 1'b1, PH_W'($urandom));
    check("to_n", to_n, 1);
    check("to_cyc", to_c, last_strobe + 1);
    check("to_fe_n", fe_n, 1);
    check("to_fe_cyc", fe_c, last_strobe + 4);
    check("to_pv", pv_n, 16);
    check("to_bv", bv_n, 15);
    check("to_resettle", int'(busy_b), 1);
    check("to_ph_left", ph_q.size(), 0);
    check("to_bit_left", bit_q.size(), 0);

    // abort in the cycle after a ph_valid
    do_reset();
    sel_b = 1'b0;
    drive(1'b0, 1'b1, 1'b1, '0);
    settle(32, 0);
    track(8, 0);
    drive(1'b1, 1'b1, 1'b1, PH_W'($urandom));
    e.val = int'($urandom_range(0, 63));
    e.cyc = cyc + 1;
    ph_q.push_back(e);
    drive(1'b1, 1'b1, 1'b1, PH_W'(e.val));
    drive(1'b1, 1'b1, 1'b1, PH_W'($urandom));
    drive(1'b1, 1'b1, 1'b0, PH_W'($urandom));
    check("ab_busy", int'(busy_a), 0);
    repeat (8) drive(1'b0, 1'b1, 1'b0, '0);
    check("ab_fe", fe_n, 0);
    check("ab_pv", pv_n, 3);
    check("ab_bv", bv_n, 1);
    check("ab_ph_left", ph_q.size(), 0);
    check("ab_bit_left", bit_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
